// File: rtl/controller.sv
// Registered instruction-control decoder: maps a 3-bit opcode to the datapath control word.
// One cycle of latency; stall holds the word, flush squashes it to NOP.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opt,
  input  logic       opt_valid,
  input  logic       stall,
  input  logic       flush,
  output logic [1:0] aluCtl,
  output logic       aluSrc,
  output logic       regWr,
  output logic       memWr,
  output logic       br,
  output logic       ctl_valid
);

  typedef struct packed {
    logic [1:0] aluCtl;
    logic       aluSrc;
    logic       regWr;
    logic       memWr;
    logic       br;
    logic       valid;
  } ctlWord_t;

  localparam ctlWord_t NopWord = '0;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluAnd = 2'd2;
  localparam logic [1:0] AluSlt = 2'd3;

  ctlWord_t decoded;
  ctlWord_t ctlReg;

  // An unknown opcode falls into the default and yields NOP, so X never leaks through decode.
  always_comb begin
    decoded = NopWord;
    case (opt)
      3'd0: decoded = '{aluCtl: AluAdd, aluSrc: 1'b0, regWr: 1'b1, memWr: 1'b0, br: 1'b0, valid: 1'b1};
      3'd1: decoded = '{aluCtl: AluSub, aluSrc: 1'b0, regWr: 1'b1, memWr: 1'b0, br: 1'b0, valid: 1'b1};
      3'd2: decoded = '{aluCtl: AluAnd, aluSrc: 1'b0, regWr: 1'b1, memWr: 1'b0, br: 1'b0, valid: 1'b1};
      3'd3: decoded = '{aluCtl: AluSlt, aluSrc: 1'b0, regWr: 1'b1, memWr: 1'b0, br: 1'b0, valid: 1'b1};
      3'd4: decoded = '{aluCtl: AluAdd, aluSrc: 1'b1, regWr: 1'b1, memWr: 1'b0, br: 1'b0, valid: 1'b1};
      3'd5: decoded = '{aluCtl: AluAdd, aluSrc: 1'b1, regWr: 1'b1, memWr: 1'b0, br: 1'b0, valid: 1'b1};
      3'd6: decoded = '{aluCtl: AluAdd, aluSrc: 1'b1, regWr: 1'b0, memWr: 1'b1, br: 1'b0, valid: 1'b1};
      3'd7: decoded = '{aluCtl: AluSub, aluSrc: 1'b0, regWr: 1'b0, memWr: 1'b0, br: 1'b1, valid: 1'b1};
      default: decoded = NopWord;
    endcase
  end

  // Flush beats stall; a stalled opcode is dropped and must be re-presented upstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctlReg <= NopWord;
    end else if (flush) begin
      ctlReg <= NopWord;
    end else if (stall) begin
      ctlReg <= ctlReg;
    end else if (opt_valid) begin
      ctlReg <= decoded;
    end else begin
      ctlReg <= NopWord;
    end
  end

  assign aluCtl    = ctlReg.aluCtl;
  assign aluSrc    = ctlReg.aluSrc;
  assign regWr     = ctlReg.regWr;
  assign memWr     = ctlReg.memWr;
  assign br        = ctlReg.br;
  assign ctl_valid = ctlReg.valid;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: vector table through a scoreboard queue, async-reset sequence,
// then a randomized phase checked against a reference model and the output invariants.
module tb_controller;

  logic       clk;
  logic       reset;
  logic [2:0] opt;
  logic       opt_valid;
  logic       stall;
  logic       flush;
  logic [1:0] aluCtl;
  logic       aluSrc;
  logic       regWr;
  logic       memWr;
  logic       br;
  logic       ctl_valid;

  logic [6:0] dutWord;
  assign dutWord = {aluCtl, aluSrc, regWr, memWr, br, ctl_valid};

  controller dut (
    .clk(clk),
    .reset(reset),
    .opt(opt),
    .opt_valid(opt_valid),
    .stall(stall),
    .flush(flush),
    .aluCtl(aluCtl),
    .aluSrc(aluSrc),
    .regWr(regWr),
    .memWr(memWr),
    .br(br),
    .ctl_valid(ctl_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: {aluCtl[1:0], aluSrc, regWr, memWr, br, ctl_valid}
  typedef struct {
    string      name;
    logic       ov;
    logic [2:0] op;
    logic       st;
    logic       fl;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] expQ[$];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [6:0] refDecode(input logic [2:0] op);
    logic [6:0] tbl [8];
    tbl[0] = 7'b00_0_1_0_0_1;
    tbl[1] = 7'b01_0_1_0_0_1;
    tbl[2] = 7'b10_0_1_0_0_1;
    tbl[3] = 7'b11_0_1_0_0_1;
    tbl[4] = 7'b00_1_1_0_0_1;
    tbl[5] = 7'b00_1_1_0_0_1;
    tbl[6] = 7'b00_1_0_1_0_1;
    tbl[7] = 7'b01_0_0_0_1_1;
    return tbl[op];
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input string name, input logic ov, input logic [2:0] op,
                        input logic st, input logic fl, input logic [6:0] exp);
    vec_t v;
    v.name = name; v.ov = ov; v.op = op; v.st = st; v.fl = fl; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, push the expectation, compare 1 time unit after the rising edge.
  task automatic applyCycle(input string name, input logic ov, input logic [2:0] op,
                            input logic st, input logic fl, input logic [6:0] exp);
    logic [6:0] e;
    @(negedge clk);
    opt_valid = ov; opt = op; stall = st; flush = fl;
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    check(name, dutWord, e);
  endtask

  logic [6:0] mdl;

  initial begin
    reset = 1'b1; opt = '0; opt_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    check("reset_initial", dutWord, 7'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    addVec("idle_after_reset", 1'b0, 3'd0, 1'b0, 1'b0, 7'b0);
    addVec("invalid_op6",      1'b0, 3'd6, 1'b0, 1'b0, 7'b0);
    addVec("sweep_add",  1'b1, 3'd0, 1'b0, 1'b0, 7'b00_0_1_0_0_1);
    addVec("sweep_sub",  1'b1, 3'd1, 1'b0, 1'b0, 7'b01_0_1_0_0_1);
    addVec("sweep_and",  1'b1, 3'd2, 1'b0, 1'b0, 7'b10_0_1_0_0_1);
    addVec("sweep_slt",  1'b1, 3'd3, 1'b0, 1'b0, 7'b11_0_1_0_0_1);
    addVec("sweep_addi", 1'b1, 3'd4, 1'b0, 1'b0, 7'b00_1_1_0_0_1);
    addVec("sweep_lw",   1'b1, 3'd5, 1'b0, 1'b0, 7'b00_1_1_0_0_1);
    addVec("sweep_sw",   1'b1, 3'd6, 1'b0, 1'b0, 7'b00_1_0_1_0_1);
    addVec("sweep_beq",  1'b1, 3'd7, 1'b0, 1'b0, 7'b01_0_0_0_1_1);
    addVec("stall_load_slt", 1'b1, 3'd3, 1'b0, 1'b0, 7'b11_0_1_0_0_1);
    addVec("stall_hold_1",   1'b1, 3'd6, 1'b1, 1'b0, 7'b11_0_1_0_0_1);
    addVec("stall_hold_2",   1'b1, 3'd6, 1'b1, 1'b0, 7'b11_0_1_0_0_1);
    addVec("stall_hold_3",   1'b1, 3'd6, 1'b1, 1'b0, 7'b11_0_1_0_0_1);
    addVec("stall_release",  1'b1, 3'd6, 1'b0, 1'b0, 7'b00_1_0_1_0_1);
    addVec("flush_load_addi", 1'b1, 3'd4, 1'b0, 1'b0, 7'b00_1_1_0_0_1);
    addVec("flush_over_stall", 1'b1, 3'd4, 1'b1, 1'b1, 7'b0);
    addVec("stall_holds_nop",  1'b1, 3'd2, 1'b1, 1'b0, 7'b0);
    addVec("load_beq",         1'b1, 3'd7, 1'b0, 1'b0, 7'b01_0_0_0_1_1);
    addVec("stall_x_opt",      1'b0, 3'bxxx, 1'b1, 1'b0, 7'b01_0_0_0_1_1);
    addVec("flush_x_opt",      1'b1, 3'bxxx, 1'b0, 1'b1, 7'b0);
    addVec("invalid_x_opt",    1'b0, 3'bxxx, 1'b0, 1'b0, 7'b0);
    addVec("load_sw",          1'b1, 3'd6, 1'b0, 1'b0, 7'b00_1_0_1_0_1);

    foreach (vecs[i])
      applyCycle(vecs[i].name, vecs[i].ov, vecs[i].op, vecs[i].st, vecs[i].fl, vecs[i].exp);

    // Asynchronous reset between edges while stalled on a valid word.
    @(negedge clk);
    stall = 1'b1; opt_valid = 1'b1; opt = 3'd1;
    #2;
    check("pre_async_reset", dutWord, 7'b00_1_0_1_0_1);
    reset = 1'b1;
    #1;
    check("async_reset_immediate", dutWord, 7'b0);
    @(posedge clk);
    #1;
    check("reset_wins_stall", dutWord, 7'b0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; opt_valid = 1'b0; opt = 3'd6;
    #1;
    check("nop_until_edge", dutWord, 7'b0);
    applyCycle("idle_after_release", 1'b0, 3'd6, 1'b0, 1'b0, 7'b0);

    mdl = 7'b0;
    for (int c = 0; c < 1000; c++) begin
      logic ov, st, fl;
      logic [2:0] op;
      logic [6:0] e;
      ov = 1'($urandom_range(0, 3) != 0);
      st = 1'($urandom_range(0, 4) == 0);
      fl = 1'($urandom_range(0, 7) == 0);
      op = 3'($urandom_range(0, 7));
      if (fl)      mdl = 7'b0;
      else if (st) mdl = mdl;
      else if (ov) mdl = refDecode(op);
      else         mdl = 7'b0;
      @(negedge clk);
      opt_valid = ov; opt = op; stall = st; flush = fl;
      expQ.push_back(mdl);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      check("random_model", dutWord, e);
      check("inv_reg_and_mem", {6'b0, regWr & memWr}, 7'b0);
      check("inv_br_with_write", {6'b0, br & (regWr | memWr)}, 7'b0);
      check("inv_write_without_valid", {6'b0, ~ctl_valid & (regWr | memWr | br)}, 7'b0);
    end

    check("scoreboard_drained", 7'(expQ.size()), 7'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
